// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Purpose:
//   Three-phase traffic light sequencer (RED -> GREEN -> YELLOW -> RED) with a
//   pedestrian request input. A single down counter holds the number of
//   remaining enabled cycles in the current phase. A pedestrian request made
//   during GREEN or YELLOW is latched in a wait flag. While the light is GREEN,
//   that flag (or a live request) cuts the remaining GREEN time to T_SHORT
//   cycles. The flag clears when the light returns to RED, which is also the
//   walk phase.
//
// Ports:
//   i_clk         clock; all state updates on the rising edge
//   i_rst_n       synchronous active-low reset
//   i_en          advance enable; phase state and counter hold while low
//   i_ped_req     pedestrian request (level or pulse), ignored during RED
//   o_red         registered RED lamp
//   o_yellow      registered YELLOW lamp
//   o_green       registered GREEN lamp
//   o_ped_walk    registered walk signal, high exactly while RED is lit
//   o_ped_wait    registered pending pedestrian request flag
//   o_cnt         registered remaining-cycles counter of the current phase
//   o_phase_done  registered one-cycle pulse in the first cycle of a new phase
//   o_state       current FSM state (RED=0, GREEN=1, YELLOW=2) for debug
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
   parameter int BUS_SIZE = 4,
   parameter int T_RED    = 5,
   parameter int T_GREEN  = 5,
   parameter int T_YELLOW = 2,
   parameter int T_SHORT  = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic                i_ped_req,
   output logic                o_red,
   output logic                o_yellow,
   output logic                o_green,
   output logic                o_ped_walk,
   output logic                o_ped_wait,
   output logic [BUS_SIZE-1:0] o_cnt,
   output logic                o_phase_done,
   output logic [1:0]          o_state
);

   typedef enum logic [1:0] {
      S_RED    = 2'd0,
      S_GREEN  = 2'd1,
      S_YELLOW = 2'd2
   } state_t;

   // Counter load values. Each phase length is at most 2^BUS_SIZE, so the
   // value length-1 always fits in BUS_SIZE bits.
   localparam logic [BUS_SIZE-1:0] C_RED_LOAD    = BUS_SIZE'(T_RED - 1);
   localparam logic [BUS_SIZE-1:0] C_GREEN_LOAD  = BUS_SIZE'(T_GREEN - 1);
   localparam logic [BUS_SIZE-1:0] C_YELLOW_LOAD = BUS_SIZE'(T_YELLOW - 1);
   localparam logic [BUS_SIZE-1:0] C_SHORT_LOAD  = BUS_SIZE'(T_SHORT - 1);
   localparam logic [BUS_SIZE-1:0] C_ONE         = BUS_SIZE'(1);

   state_t              r_state;
   logic [BUS_SIZE-1:0] r_cnt;
   logic                r_red;
   logic                r_yellow;
   logic                r_green;
   logic                r_ped_walk;
   logic                r_ped_wait;
   logic                r_phase_done;

   logic w_cnt_zero;
   logic w_ped_set;
   logic w_shorten;

   assign w_cnt_zero = (r_cnt == '0);

   // A request counts only outside RED. The set happens on every edge,
   // whether or not the light is advancing.
   assign w_ped_set  = i_ped_req && (r_state != S_RED);

   // Shorten GREEN only if that actually reduces the remaining time.
   // A counter already at or below T_SHORT-1 keeps counting down normally.
   assign w_shorten  = (r_state == S_GREEN) && (r_ped_wait || i_ped_req) &&
                       (r_cnt > C_SHORT_LOAD);

   // Phase sequencer. Each edge applies at most one counter rule, in this
   // order of precedence: phase transition at zero, then GREEN shortening,
   // then a plain decrement. The lamps are computed from the state being
   // entered, so they change on the same edge as the state.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_RED;
         r_cnt        <= C_RED_LOAD;
         r_red        <= 1'b1;
         r_yellow     <= 1'b0;
         r_green      <= 1'b0;
         r_ped_walk   <= 1'b1;
         r_ped_wait   <= 1'b0;
         r_phase_done <= 1'b0;
      end else begin
         r_phase_done <= 1'b0;

         if (w_ped_set) begin
            r_ped_wait <= 1'b1;
         end

         if (i_en) begin
            if (w_cnt_zero) begin
               r_phase_done <= 1'b1;
               case (r_state)
                  S_RED: begin
                     r_state    <= S_GREEN;
                     r_cnt      <= C_GREEN_LOAD;
                     r_red      <= 1'b0;
                     r_yellow   <= 1'b0;
                     r_green    <= 1'b1;
                     r_ped_walk <= 1'b0;
                  end
                  S_GREEN: begin
                     r_state    <= S_YELLOW;
                     r_cnt      <= C_YELLOW_LOAD;
                     r_red      <= 1'b0;
                     r_yellow   <= 1'b1;
                     r_green    <= 1'b0;
                     r_ped_walk <= 1'b0;
                  end
                  default: begin
                     // YELLOW (and any unreachable encoding) returns to RED.
                     // Entering RED serves the pending request. This later
                     // assignment overrides a set on the same edge.
                     r_state    <= S_RED;
                     r_cnt      <= C_RED_LOAD;
                     r_red      <= 1'b1;
                     r_yellow   <= 1'b0;
                     r_green    <= 1'b0;
                     r_ped_walk <= 1'b1;
                     r_ped_wait <= 1'b0;
                  end
               endcase
            end else if (w_shorten) begin
               r_cnt <= C_SHORT_LOAD;
            end else begin
               // The counter is nonzero here, so it cannot wrap.
               r_cnt <= r_cnt - C_ONE;
            end
         end
      end
   end

   assign o_red        = r_red;
   assign o_yellow     = r_yellow;
   assign o_green      = r_green;
   assign o_ped_walk   = r_ped_walk;
   assign o_ped_wait   = r_ped_wait;
   assign o_cnt        = r_cnt;
   assign o_phase_done = r_phase_done;
   assign o_state      = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Self-checking bench for traffic_light_ctrl with the default parameters.
// A phase-level reference model tracks the phase index, the remaining cycles
// and the request flag as plain integers. Directed scenarios check the
// constants that the sequence requires. A randomized run compares every
// output to the model on every cycle.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

  localparam int BUS_SIZE = 4;
  localparam int T_RED    = 5;
  localparam int T_GREEN  = 5;
  localparam int T_YELLOW = 2;
  localparam int T_SHORT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                i_rst_n   = 1'b0;
  logic                i_en      = 1'b0;
  logic                i_ped_req = 1'b0;
  logic                o_red, o_yellow, o_green, o_ped_walk, o_ped_wait;
  logic [BUS_SIZE-1:0] o_cnt;
  logic                o_phase_done;
  logic [1:0]          o_state;

  traffic_light_ctrl #(
    .BUS_SIZE(BUS_SIZE), .T_RED(T_RED), .T_GREEN(T_GREEN),
    .T_YELLOW(T_YELLOW), .T_SHORT(T_SHORT)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_ped_req(i_ped_req),
    .o_red(o_red), .o_yellow(o_yellow), .o_green(o_green),
    .o_ped_walk(o_ped_walk), .o_ped_wait(o_ped_wait), .o_cnt(o_cnt),
    .o_phase_done(o_phase_done), .o_state(o_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  // Phase index: 0 = RED, 1 = GREEN, 2 = YELLOW.
  int m_phase = 0;
  int m_cnt   = T_RED - 1;
  bit m_wait  = 1'b0;
  bit m_done  = 1'b0;

  function automatic int phase_len(input int p);
    if (p == 0) return T_RED;
    if (p == 1) return T_GREEN;
    return T_YELLOW;
  endfunction

  function automatic logic [9:0] model_vec();
    logic [3:0] c;
    c = 4'(m_cnt);
    return {m_phase == 0, m_phase == 2, m_phase == 1, m_phase == 0,
            m_wait, m_done, c};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {o_red, o_yellow, o_green, o_ped_walk, o_ped_wait, o_phase_done, o_cnt};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the falling edge and advances the model at
  // the rising edge. Outputs are then stable for sampling 1ns later.
  task automatic tick(input logic rst_n, input logic en, input logic ped);
    bit nw, nd;
    @(negedge clk);
    i_rst_n   = rst_n;
    i_en      = en;
    i_ped_req = ped;
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_cnt = T_RED - 1; m_wait = 1'b0; m_done = 1'b0;
    end else begin
      nw = m_wait || (ped && m_phase != 0);
      nd = 1'b0;
      if (en) begin
        if (m_cnt == 0) begin
          m_phase = (m_phase + 1) % 3;
          m_cnt   = phase_len(m_phase) - 1;
          nd      = 1'b1;
          if (m_phase == 0) nw = 1'b0;
        end else if (m_phase == 1 && (m_wait || ped) && m_cnt > T_SHORT - 1) begin
          m_cnt = T_SHORT - 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      m_wait = nw;
      m_done = nd;
    end
    #1;
  endtask

  // Free-runs with no requests until the model reaches the given phase and
  // count, with a bounded number of cycles.
  task automatic run_until(input int p, input int c);
    int n;
    n = 0;
    while (!(m_phase == p && m_cnt == c) && n < 40) begin
      tick(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (!(m_phase == p && m_cnt == c)) begin
      n_total++;
      $display("FAIL run_until: phase %0d cnt %0d not reached, at phase %0d cnt %0d",
               p, c, m_phase, m_cnt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    n_total++; if (o_red !== 1'b1) $display("FAIL reset_red: got %b want 1", o_red); else n_pass++;
    n_total++; if ({o_yellow, o_green} !== 2'b00) $display("FAIL reset_yg: got %b want 00", {o_yellow, o_green}); else n_pass++;
    n_total++; if (o_ped_walk !== 1'b1) $display("FAIL reset_walk: got %b want 1", o_ped_walk); else n_pass++;
    n_total++; if (o_cnt !== 4'd4) $display("FAIL reset_cnt: got %0d want 4", o_cnt); else n_pass++;
    n_total++; if (o_ped_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", o_ped_wait); else n_pass++;
    n_total++; if (o_phase_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_phase_done); else n_pass++;
  endtask

  task automatic test_free_run();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (o_phase_done === 1'b1) pulses++;
      n_total++;
      if (dut_vec() !== model_vec())
        $display("FAIL free_run cycle %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++; if (pulses !== 6) $display("FAIL free_run_pulses: got %0d want 6", pulses); else n_pass++;
    n_total++; if ({o_red, o_cnt} !== {1'b1, 4'd4}) $display("FAIL free_run_period: got red %b cnt %0d want red 1 cnt 4", o_red, o_cnt); else n_pass++;
  endtask

  task automatic test_ped_shorten();
    run_until(1, 4);
    tick(1'b1, 1'b1, 1'b1);
    n_total++; if ({o_green, o_cnt, o_ped_wait} !== {1'b1, 4'd1, 1'b1}) $display("FAIL short_cut: got g %b cnt %0d wait %b want g 1 cnt 1 wait 1", o_green, o_cnt, o_ped_wait); else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_green, o_cnt, o_ped_wait} !== {1'b1, 4'd0, 1'b1}) $display("FAIL short_zero: got g %b cnt %0d wait %b want g 1 cnt 0 wait 1", o_green, o_cnt, o_ped_wait); else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_yellow, o_cnt, o_ped_wait, o_phase_done} !== {1'b1, 4'd1, 1'b1, 1'b1}) $display("FAIL short_yellow: got y %b cnt %0d wait %b done %b want 1 1 1 1", o_yellow, o_cnt, o_ped_wait, o_phase_done); else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_red, o_cnt, o_ped_wait, o_phase_done} !== {1'b1, 4'd4, 1'b0, 1'b1}) $display("FAIL short_red: got r %b cnt %0d wait %b done %b want 1 4 0 1", o_red, o_cnt, o_ped_wait, o_phase_done); else n_pass++;
  endtask

  task automatic test_ped_no_shorten();
    run_until(1, 1);
    tick(1'b1, 1'b1, 1'b1);
    n_total++; if ({o_green, o_cnt, o_ped_wait} !== {1'b1, 4'd0, 1'b1}) $display("FAIL noshort_cnt: got g %b cnt %0d wait %b want g 1 cnt 0 wait 1", o_green, o_cnt, o_ped_wait); else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_yellow, o_cnt, o_phase_done} !== {1'b1, 4'd1, 1'b1}) $display("FAIL noshort_yellow: got y %b cnt %0d done %b want 1 1 1", o_yellow, o_cnt, o_phase_done); else n_pass++;
  endtask

  task automatic test_enable_hold();
    run_until(2, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_total++;
      if ({o_yellow, o_red, o_green, o_cnt, o_phase_done} !== {1'b1, 1'b0, 1'b0, 4'd1, 1'b0})
        $display("FAIL hold_%0d: got y %b r %b g %b cnt %0d done %b want 1 0 0 1 0", i, o_yellow, o_red, o_green, o_cnt, o_phase_done);
      else n_pass++;
    end
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_yellow, o_cnt, o_phase_done} !== {1'b1, 4'd0, 1'b0}) $display("FAIL hold_resume: got y %b cnt %0d done %b want 1 0 0", o_yellow, o_cnt, o_phase_done); else n_pass++;
    tick(1'b1, 1'b1, 1'b0);
    n_total++; if ({o_red, o_ped_walk, o_cnt, o_ped_wait, o_phase_done} !== {1'b1, 1'b1, 4'd4, 1'b0, 1'b1}) $display("FAIL hold_red: got r %b walk %b cnt %0d wait %b done %b want 1 1 4 0 1", o_red, o_ped_walk, o_cnt, o_ped_wait, o_phase_done); else n_pass++;
  endtask

  task automatic test_mid_reset();
    run_until(1, 2);
    tick(1'b1, 1'b0, 1'b1);
    n_total++; if ({o_green, o_cnt, o_ped_wait} !== {1'b1, 4'd2, 1'b1}) $display("FAIL midrst_setup: got g %b cnt %0d wait %b want 1 2 1", o_green, o_cnt, o_ped_wait); else n_pass++;
    tick(1'b0, 1'b1, 1'b0);
    n_total++; if ({o_red, o_green, o_cnt, o_ped_wait, o_phase_done} !== {1'b1, 1'b0, 4'd4, 1'b0, 1'b0}) $display("FAIL midrst: got r %b g %b cnt %0d wait %b done %b want 1 0 4 0 0", o_red, o_green, o_cnt, o_ped_wait, o_phase_done); else n_pass++;
  endtask

  task automatic test_random();
    logic rst_n, en, ped;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      en    = ($urandom_range(0, 3) != 0);
      ped   = ($urandom_range(0, 4) == 0);
      tick(rst_n, en, ped);
      n_total++;
      if (dut_vec() !== model_vec())
        $display("FAIL random cycle %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
      n_total++;
      if ($countones({o_red, o_yellow, o_green}) != 1 || o_ped_walk !== o_red)
        $display("FAIL random_lamps cycle %0d: got ryg %b walk %b want one-hot, walk==red", i, {o_red, o_yellow, o_green}, o_ped_walk);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_shorten();
    test_ped_no_shorten();
    test_enable_hold();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
